fle_frac_param: RTL and testbench
=================================

FLE_FRAC_PARAM -- requirements
Module: fle_frac_param

Interface
REQ-001 Parameter K, default 4, gives the LUT input count; legal range 3..6.
REQ-002 Derived constant CFG_W = 2^K + 4 gives the configuration chain length (20 for K=4).
REQ-003 prog_clk  input  1  the sole clock; all state updates on its rising edge.
REQ-004 prog_reset  input  1  synchronous active-high reset, sampled on the prog_clk rising edge.
REQ-005 test_enable  input  1  scan mode; the two FFs form a shift chain.
REQ-006 ccff_en  input  1  configuration shift enable.
REQ-007 ccff_head  input  1  configuration serial in.
REQ-008 fle_in  input  [0:K-1]  LUT inputs; LUT address bit i = fle_in[i].
REQ-009 fle_sc_in  input  1  scan serial in.
REQ-010 fle_cin  input  1  carry in.
REQ-011 fle_out  output  [0:1]  element outputs.
REQ-012 fle_sc_out  output  1  scan serial out, equal to ff[1].
REQ-013 fle_cout  output  1  carry out, combinational.
REQ-014 ccff_tail  output  1  configuration serial out, equal to cfg[CFG_W-1].

Function
REQ-015 Configuration register layout:
- cfg[0:2^K-1] is mask.
- cfg[2^K] is frac.
- cfg[2^K+1] is carry_en.
- cfg[2^K+2+j] is regsel[j], for j = 0..1.
REQ-016 Shift on every edge with ccff_en=1: cfg[0] <= ccff_head and cfg[i] <= cfg[i-1]; the first bit shifted in lands in cfg[CFG_W-1] after CFG_W edges.
REQ-017 With ccff_en=0 the cfg register holds its value.
REQ-018 Unfractured mode, frac=0:
- comb[0] = comb[1] = mask[addr], where addr is formed from fle_in[0:K-1].
REQ-019 Fractured mode, frac=1:
- h = (K-1)-bit address from fle_in[0:K-2].
- lo = mask[h]; hi = mask[2^(K-1)+h].
- comb[0] = lo; comb[1] = hi.
- fle_in[K-1] is ignored.
REQ-020 Carry mode, frac=1 and carry_en=1:
- comb[0] = lo XOR fle_cin.
- fle_cout = lo ? fle_cin : hi.
- comb[1] = hi.
REQ-021 fle_cout = 0 whenever carry_en=0 or frac=0.
REQ-022 carry_en is ignored when frac=0.
REQ-023 Normal mode (ccff_en=0, test_enable=0): ff[j] <= comb[j] every edge.
REQ-024 Scan mode (test_enable=1, ccff_en=0): ff[0] <= fle_sc_in and ff[1] <= ff[0].
REQ-025 fle_out[j] = regsel[j] ? ff[j] : comb[j].
REQ-026 Update priority per edge: prog_reset, then ccff_en, then test_enable, then normal.
REQ-027 While ccff_en=1:
- ff holds its value.
- fle_out = 2'b00 and fle_cout = 0, forced combinationally.
- fle_sc_out still shows ff[1].
REQ-028 Latency:
- comb paths: 0 cycles.
- registered outputs: 1 edge.
- ccff_head to ccff_tail: CFG_W edges.

Reset
REQ-029 prog_reset=1 on an edge clears cfg to all zeros and ff to 00.
REQ-030 After reset all outputs read 0: fle_out, fle_sc_out, fle_cout and ccff_tail.
REQ-031 Reset asserted mid-configuration discards the partial load; a full CFG_W-bit reload is required afterwards.
REQ-032 Reset overrides ccff_en and test_enable on the same edge.

Structure
REQ-033 Package fle_param_pkg shall hold:
- the CFG_W function of K;
- the offset constants for mask, frac, carry_en and regsel.
REQ-034 One sub-module fle_lut_frac shall hold the combinational LUT, fracture and carry logic (mask, frac, carry_en, fle_in, fle_cin -> comb, fle_cout).
REQ-035 The cfg shift register and the FFs shall live in the top module.

Verification (K=4)
REQ-036 Reset check: assert reset with ccff_head=1, ccff_en=0, test_enable=0 -> all outputs 0; cfg reads 0 via a 20-edge shift-out on ccff_tail.
REQ-037 Configure mask=0x8000 (AND4), frac=0, regsel=00:
- fle_in=1111 -> fle_out=11 combinationally.
- fle_in=1110 -> fle_out=00.
- The first shifted bit appears on ccff_tail after edge 20.
REQ-038 Fractured: mask lower=0x96 (XOR3), upper=0xE8 (MAJ3), frac=1, fle_in[0:2]=1,1,0 -> fle_out=01. With regsel=11 the same value appears one edge later.
REQ-039 Carry: lower=0x66, upper=0x88, frac=1, carry_en=1:
- in0=1, in1=1, cin=1 -> fle_out[0]=1, fle_cout=1.
- in0=1, in1=0, cin=1 -> fle_out[0]=0, fle_cout=1.
REQ-040 Scan: test_enable=1, drive fle_sc_in=1 then 0 -> fle_sc_out=1 after edge 2 and 0 after edge 3.
REQ-041 Reset mid-load: shift 7 bits, assert reset for 1 edge -> cfg=0 and fle_out=00; a full 20-bit reload then restores the AND4 function.

Source files
------------

// File: rtl/fle_param_pkg.sv
// fle_param_pkg: config chain length and field offsets for the fracturable logic element
package fle_param_pkg;
  localparam int MASK_OFS = 0;
  function automatic int cfg_w(input int k);
    return (1 << k) + 4;
  endfunction
  function automatic int frac_ofs(input int k);
    return 1 << k;
  endfunction
  function automatic int carry_ofs(input int k);
    return (1 << k) + 1;
  endfunction
  function automatic int regsel_ofs(input int k);
    return (1 << k) + 2;
  endfunction
endpackage

// File: rtl/fle_lut_frac.sv
// fle_lut_frac: K-input LUT that fractures into two (K-1)-input LUTs with optional carry
module fle_lut_frac #(
  parameter int K = 4
) (
  input  logic [0:(1<<K)-1] mask,
  input  logic              frac,
  input  logic              carry_en,
  input  logic [0:K-1]      fle_in,
  input  logic              fle_cin,
  output logic [0:1]        comb,
  output logic              fle_cout
);
  logic [K-1:0] addr;
  logic full, lo, hi, carry;
  for (genvar i = 0; i < K; i++) begin : g_addr
    assign addr[i] = fle_in[i];
  end
  assign full = mask[addr];
  assign lo = mask[{1'b0, addr[K-2:0]}];
  assign hi = mask[{1'b1, addr[K-2:0]}];
  assign carry = frac & carry_en;
  assign comb[0] = frac ? lo ^ (carry & fle_cin) : full;
  assign comb[1] = frac ? hi : full;
  assign fle_cout = carry & (lo ? fle_cin : hi);
endmodule

// File: rtl/fle_frac_param.sv
// fle_frac_param: fracturable logic element with serial config chain and scan-capable output FFs
module fle_frac_param
  import fle_param_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  input  logic         test_enable,
  input  logic         ccff_en,
  input  logic         ccff_head,
  input  logic [0:K-1] fle_in,
  input  logic         fle_sc_in,
  input  logic         fle_cin,
  output logic [0:1]   fle_out,
  output logic         fle_sc_out,
  output logic         fle_cout,
  output logic         ccff_tail
);
  localparam int CFG_W = cfg_w(K);
  localparam int M = 1 << K;
  logic [0:CFG_W-1] cfg;
  logic [0:1] ff, comb, regsel;
  logic cout_raw;
  assign regsel = cfg[regsel_ofs(K) +: 2];
  fle_lut_frac #(.K(K)) u_lut (
    .mask(cfg[MASK_OFS +: M]),
    .frac(cfg[frac_ofs(K)]),
    .carry_en(cfg[carry_ofs(K)]),
    .fle_in(fle_in),
    .fle_cin(fle_cin),
    .comb(comb),
    .fle_cout(cout_raw)
  );
  // config shifts while enabled and freezes the FFs; otherwise FFs scan or capture the LUT
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cfg <= '0;
      ff <= '0;
    end else if (ccff_en) cfg <= {ccff_head, cfg[0:CFG_W-2]};
    else ff <= test_enable ? {fle_sc_in, ff[0]} : comb;
  end
  assign fle_out[0] = ~ccff_en & (regsel[0] ? ff[0] : comb[0]);
  assign fle_out[1] = ~ccff_en & (regsel[1] ? ff[1] : comb[1]);
  assign fle_cout = ~ccff_en & cout_raw;
  assign fle_sc_out = ff[1];
  assign ccff_tail = cfg[CFG_W-1];
endmodule

// File: tb/tb_fle_frac_param.sv
// tb_fle_frac_param: table vectors, corner sequences and randomized model check for fle_frac_param
module tb_fle_frac_param;
  logic prog_clk = 0, prog_reset = 0, test_enable = 0, ccff_en = 0, ccff_head = 0;
  logic [0:3] fle_in = '0;
  logic fle_sc_in = 0, fle_cin = 0;
  logic [0:1] fle_out;
  logic fle_sc_out, fle_cout, ccff_tail;
  int passed = 0, total = 0;

  fle_frac_param #(.K(4)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .test_enable(test_enable),
    .ccff_en(ccff_en), .ccff_head(ccff_head), .fle_in(fle_in), .fle_sc_in(fle_sc_in),
    .fle_cin(fle_cin), .fle_out(fle_out), .fle_sc_out(fle_sc_out), .fle_cout(fle_cout),
    .ccff_tail(ccff_tail)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [15:0] mask;
    logic frac, cen;
    logic [3:0] addr;
    logic cin;
    int exp;
  } vec_t;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  function automatic int outs();
    return int'({fle_out[0], fle_out[1], fle_cout});
  endfunction

  task automatic set_in(input logic [3:0] a);
    for (int i = 0; i < 4; i++) fle_in[i] = a[i];
  endtask

  function automatic logic [0:19] mk_cfg(input logic [15:0] m, input logic f, c, input logic [1:0] rs);
    logic [0:19] v;
    for (int i = 0; i < 16; i++) v[i] = m[i];
    v[16] = f;
    v[17] = c;
    v[18] = rs[0];
    v[19] = rs[1];
    return v;
  endfunction

  task automatic shift_range(input logic [0:19] v, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) begin
      ccff_en = 1;
      ccff_head = v[k];
      tick();
    end
    ccff_en = 0;
    ccff_head = 0;
  endtask

  task automatic load_cfg(input logic [15:0] m, input logic f, c, input logic [1:0] rs);
    shift_range(mk_cfg(m, f, c, rs), 19, 0);
  endtask

  task automatic do_reset();
    prog_reset = 1;
    tick();
    prog_reset = 0;
  endtask

  // {out0, out1, cout} as a 3-bit number, derived directly from the LUT/fracture/carry rules
  function automatic int model(input logic [15:0] m, input logic f, c, input int a, input logic ci);
    int mi, lo, hi, cv;
    mi = int'(m);
    cv = int'(ci);
    if (!f) return ((mi >> a) & 1) * 6;
    lo = (mi >> (a % 8)) & 1;
    hi = (mi >> (8 + a % 8)) & 1;
    if (c) return ((lo ^ cv) * 4) + hi * 2 + (lo != 0 ? cv : hi);
    return lo * 4 + hi * 2;
  endfunction

  initial begin
    vec_t tbl[8];
    int first, bad;
    logic ff0m, ff1m;
    tbl[0] = '{16'h8000, 0, 0, 4'd15, 0, 6};
    tbl[1] = '{16'h8000, 0, 0, 4'd7,  0, 0};
    tbl[2] = '{16'h8000, 0, 1, 4'd15, 1, 6};
    tbl[3] = '{16'hE896, 1, 0, 4'd3,  0, 2};
    tbl[4] = '{16'hE896, 1, 0, 4'd11, 1, 2};
    tbl[5] = '{16'h8866, 1, 1, 4'd3,  1, 7};
    tbl[6] = '{16'h8866, 1, 1, 4'd1,  1, 1};
    tbl[7] = '{16'h8866, 1, 1, 4'd0,  1, 4};

    ccff_head = 1;
    do_reset();
    ccff_head = 0;
    check("reset_out", outs(), 0);
    check("reset_sc_out", int'(fle_sc_out), 0);
    check("reset_tail", int'(ccff_tail), 0);
    bad = 0;
    for (int e = 0; e < 20; e++) begin
      ccff_en = 1;
      tick();
      bad += int'(ccff_tail);
    end
    ccff_en = 0;
    check("reset_shiftout", bad, 0);

    first = 0;
    for (int e = 1; e <= 20; e++) begin
      ccff_en = 1;
      ccff_head = (e == 1);
      tick();
      if (ccff_tail && first == 0) first = e;
    end
    ccff_en = 0;
    check("tail_latency", first, 20);

    for (int i = 0; i < 8; i++) begin
      load_cfg(tbl[i].mask, tbl[i].frac, tbl[i].cen, 2'b00);
      set_in(tbl[i].addr);
      fle_cin = tbl[i].cin;
      #1;
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    load_cfg(16'h8866, 1, 1, 2'b00);
    set_in(4'd3);
    fle_cin = 1;
    #1;
    check("pre_force", outs(), 7);
    ccff_en = 1;
    #1;
    check("ccff_force", outs(), 0);
    ccff_en = 0;

    load_cfg(16'hE896, 1, 0, 2'b11);
    set_in(4'd3);
    fle_cin = 0;
    tick();
    check("regsel_after_edge", outs(), 2);
    set_in(4'd0);
    #1;
    check("regsel_held", outs(), 2);
    tick();
    check("regsel_update", outs(), 0);

    test_enable = 1;
    fle_sc_in = 1;
    tick();
    fle_sc_in = 0;
    tick();
    check("scan_edge2", int'(fle_sc_out), 1);
    tick();
    check("scan_edge3", int'(fle_sc_out), 0);
    test_enable = 0;

    do_reset();
    shift_range(mk_cfg(16'h8000, 0, 0, 2'b00), 19, 13);
    do_reset();
    set_in(4'd15);
    #1;
    check("midload_reset_out", outs(), 0);
    check("midload_reset_tail", int'(ccff_tail), 0);
    shift_range(mk_cfg(16'h8000, 0, 0, 2'b00), 12, 0);
    set_in(4'd15);
    #1;
    check("midload_discard", outs(), 0);
    load_cfg(16'h8000, 0, 0, 2'b00);
    set_in(4'd15);
    #1;
    check("midload_reload", outs(), 6);

    do_reset();
    ff0m = 0;
    ff1m = 0;
    for (int c = 0; c < 20; c++) begin
      logic [15:0] m;
      logic f, ce;
      logic [1:0] rs;
      m = 16'($urandom);
      f = 1'($urandom);
      ce = 1'($urandom);
      rs = 2'($urandom);
      load_cfg(m, f, ce, rs);
      for (int n = 0; n < 10; n++) begin
        int a, cm, e0, e1, ec;
        logic ci, te, sc;
        a = int'($urandom_range(0, 15));
        ci = 1'($urandom);
        te = ($urandom_range(0, 3) == 0);
        sc = 1'($urandom);
        set_in(4'(a));
        fle_cin = ci;
        test_enable = te;
        fle_sc_in = sc;
        #1;
        cm = model(m, f, ce, a, ci);
        e0 = rs[0] ? int'(ff0m) : (cm >> 2) & 1;
        e1 = rs[1] ? int'(ff1m) : (cm >> 1) & 1;
        ec = cm & 1;
        check($sformatf("rand_c%0d_n%0d", c, n), outs(), e0 * 4 + e1 * 2 + ec);
        check($sformatf("rand_sc_c%0d_n%0d", c, n), int'(fle_sc_out), int'(ff1m));
        tick();
        if (te) begin
          ff1m = ff0m;
          ff0m = sc;
        end else begin
          ff0m = 1'((cm >> 2) & 1);
          ff1m = 1'((cm >> 1) & 1);
        end
      end
      test_enable = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
